neopixel_serializer: RTL

Downstream WS2812 line driver. It sits behind the ChipInterface pixel store and owns the strip output pin. On `go` it reads NUM_PIXELS 24-bit GRB words from the upstream pixel memory and emits them MSB-first as the NeoPixel one-wire waveform, with no gaps between bits or pixels. It then holds the line low for the latch period and reasserts `ready`.

---
 rtl/neopixel_serializer_if.sv | 34 +++
 rtl/neopixel_serializer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/neopixel_serializer_if.sv
// Pixel-memory / control / strip-pin bundle for the WS2812 serializer.
// The master side is the upstream controller, which owns the pixel store
// and the go request. The slave side is the serializer, which owns the
// address, the status flags and the strip output.
interface neopixel_serializer_if #(
    parameter int NUM_PIXELS = 16
);
    localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    logic          go;
    logic [AW-1:0] pixel_addr;
    logic [23:0]   pixel_data;
    logic          ready;
    logic          neo_out;
    logic          frame_done;

    modport master (
        output go,
        output pixel_data,
        input  pixel_addr,
        input  ready,
        input  neo_out,
        input  frame_done
    );

    modport slave (
        input  go,
        input  pixel_data,
        output pixel_addr,
        output ready,
        output neo_out,
        output frame_done
    );
endinterface

// File: rtl/neopixel_serializer.sv
// WS2812 one-wire line driver.
// On go it fetches NUM_PIXELS GRB words from a memory with one cycle of read
// latency. It shifts each word out MSB-first as back-to-back bit cells of
// BIT_CYCLES clocks, with no gaps between bits or pixels. It then holds the
// line low for LATCH_CYCLES and pulses frame_done.
// neo_out and frame_done are registered from next-state values, so the
// strip pin comes straight from a flop and cannot glitch.
// T0H_CYCLES < T1H_CYCLES < BIT_CYCLES must hold for a usable waveform.
module neopixel_serializer #(
    parameter int NUM_PIXELS   = 16,
    parameter int BIT_CYCLES   = 63,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    neopixel_serializer_if.slave  bus
);
    localparam int AW   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int CMAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] C_BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] C_LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] C_T0H        = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] C_T1H        = CW'(T1H_CYCLES);
    localparam logic [AW-1:0] A_LAST       = AW'(NUM_PIXELS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [23:0]   r_shift;
    logic [4:0]    r_bit;
    logic [AW-1:0] r_pix;
    logic [AW-1:0] r_addr;
    logic          r_neo;
    logic          r_done;

    logic [1:0]    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [23:0]   w_shift_next;
    logic [4:0]    w_bit_next;
    logic [AW-1:0] w_pix_next;
    logic [AW-1:0] w_addr_next;
    logic [AW-1:0] w_addr_inc;
    logic [CW-1:0] w_thx;
    logic          w_neo_next;
    logic          w_done_next;

    // The fetch address saturates on the last pixel and never wraps mid-frame.
    assign w_addr_inc = (r_addr == A_LAST) ? r_addr : r_addr + 1'b1;

    // Frame sequencing: next state, counters, shift register and fetch address.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_pix_next   = r_pix;
        w_addr_next  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // Address 0 has been presented for at least one cycle, so
                // pixel 0 is on pixel_data now. Prefetch of pixel 1 starts here.
                w_state_next = S_SEND;
                w_shift_next = bus.pixel_data;
                w_bit_next   = 5'd23;
                w_cnt_next   = '0;
                w_pix_next   = '0;
                w_addr_next  = w_addr_inc;
            end
            S_SEND: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_next = '0;
                    if (r_bit == 5'd0) begin
                        if (r_pix == A_LAST) begin
                            w_state_next = S_LATCH;
                            w_addr_next  = '0;
                        end else begin
                            // The next pixel was addressed a whole pixel
                            // earlier, so it can be loaded without a gap.
                            w_shift_next = bus.pixel_data;
                            w_bit_next   = 5'd23;
                            w_pix_next   = r_pix + 1'b1;
                            w_addr_next  = w_addr_inc;
                        end
                    end else begin
                        w_shift_next = {r_shift[22:0], 1'b0};
                        w_bit_next   = r_bit - 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_cnt == C_LATCH_LAST) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_addr_next  = '0;
            end
        endcase

        w_thx       = w_shift_next[23] ? C_T1H : C_T0H;
        w_neo_next  = (w_state_next == S_SEND) && (w_cnt_next < w_thx);
        w_done_next = (w_state_next == S_LATCH) && (w_cnt_next == C_LATCH_LAST);
    end

    // State and output registers. The asynchronous reset drops the line at once.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_pix   <= '0;
            r_addr  <= '0;
            r_neo   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_bit   <= w_bit_next;
            r_pix   <= w_pix_next;
            r_addr  <= w_addr_next;
            r_neo   <= w_neo_next;
            r_done  <= w_done_next;
        end
    end

    assign bus.pixel_addr = r_addr;
    assign bus.ready      = (r_state == S_IDLE);
    assign bus.neo_out    = r_neo;
    assign bus.frame_done = r_done;
endmodule
